// File: rtl/cronometro_bcd.sv
// cronometro_bcd: BCD MM:SS stopwatch counting divider ticks.
//
// Build option: define CRONO_ALARM_EN to add the alarma output and its
// comparator against ALARM_MIN:ALARM_SEG.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   tick       one-cycle count pulse from the divider
//   btn_start  start level (synchronised, debounced)
//   btn_stop   stop level (synchronised, debounced)
//   btn_clear  clear level (synchronised, debounced)
//   inicio     divider enable, high while RUN
//   seg_u/seg_d/min_u/min_d  BCD digits of MM:SS
//   running    copy of inicio
//   wrap       one-cycle pulse on 59:59 -> 00:00
//   alarma     one-cycle pulse on reaching the alarm time (option only)
//
// state | meaning
// IDLE  | stopped at 00:00
// RUN   | counting ticks, divider enabled
// PAUSE | frozen at current value
module cronometro_bcd #(
  parameter int unsigned ALARM_MIN = 1,
  parameter int unsigned ALARM_SEG = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  output logic       inicio,
  output logic [3:0] seg_u,
  output logic [3:0] seg_d,
  output logic [3:0] min_u,
  output logic [3:0] min_d,
  output logic       running,
`ifdef CRONO_ALARM_EN
  output logic       alarma,
`endif
  output logic       wrap
);

  if (ALARM_MIN > 59 || ALARM_SEG > 59) begin : g_bad_alarm
    $error("cronometro_bcd: alarm time out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t     state_q, state_d;
  // Bit order {clear, stop, start}. btn_s_q samples the inputs, btn_q is
  // the previous sample; both reset to 1 so a held button gives no edge.
  logic [2:0] btn_s_q, btn_q;
  logic [2:0] btn_edge;
  logic [3:0] seg_u_q, seg_u_d, seg_d_q, seg_d_d;
  logic [3:0] min_u_q, min_u_d, min_d_q, min_d_d;
  logic       inicio_q, inicio_d;
  logic       wrap_q, wrap_d;
  logic       start_e, stop_e, clear_e, cnt_en;
`ifdef CRONO_ALARM_EN
  localparam logic [15:0] ALARM_BCD = {4'(ALARM_MIN / 10), 4'(ALARM_MIN % 10),
                                       4'(ALARM_SEG / 10), 4'(ALARM_SEG % 10)};
  logic alarma_q, alarma_d;
`endif

  assign btn_edge = btn_s_q & ~btn_q;
  assign start_e  = btn_edge[0];
  assign stop_e   = btn_edge[1];
  assign clear_e  = btn_edge[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      btn_s_q  <= 3'b111;
      btn_q    <= 3'b111;
      seg_u_q  <= 4'd0;
      seg_d_q  <= 4'd0;
      min_u_q  <= 4'd0;
      min_d_q  <= 4'd0;
      inicio_q <= 1'b0;
      wrap_q   <= 1'b0;
`ifdef CRONO_ALARM_EN
      alarma_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      btn_s_q  <= {btn_clear, btn_stop, btn_start};
      btn_q    <= btn_s_q;
      seg_u_q  <= seg_u_d;
      seg_d_q  <= seg_d_d;
      min_u_q  <= min_u_d;
      min_d_q  <= min_d_d;
      inicio_q <= inicio_d;
      wrap_q   <= wrap_d;
`ifdef CRONO_ALARM_EN
      alarma_q <= alarma_d;
`endif
    end
  end

  // Priority clear > start > stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_e) state_d = S_RUN;
      S_RUN: begin
        if (clear_e)     state_d = S_IDLE;
        else if (stop_e) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (clear_e)      state_d = S_IDLE;
        else if (start_e) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inicio_d = (state_d == S_RUN);
  end

  // A tick is counted off the current state, so stop in the same cycle
  // still counts it; clear overrides it.
  assign cnt_en = (state_q == S_RUN) && tick && !clear_e;

  always_comb begin
    seg_u_d = seg_u_q;
    seg_d_d = seg_d_q;
    min_u_d = min_u_q;
    min_d_d = min_d_q;
    wrap_d  = 1'b0;
    if (clear_e) begin
      seg_u_d = 4'd0;
      seg_d_d = 4'd0;
      min_u_d = 4'd0;
      min_d_d = 4'd0;
    end else if (cnt_en) begin
      if (seg_u_q != 4'd9) seg_u_d = seg_u_q + 4'd1;
      else begin
        seg_u_d = 4'd0;
        if (seg_d_q != 4'd5) seg_d_d = seg_d_q + 4'd1;
        else begin
          seg_d_d = 4'd0;
          if (min_u_q != 4'd9) min_u_d = min_u_q + 4'd1;
          else begin
            min_u_d = 4'd0;
            if (min_d_q != 4'd5) min_d_d = min_d_q + 4'd1;
            else begin
              min_d_d = 4'd0;
              wrap_d  = 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef CRONO_ALARM_EN
  // Only a counted tick can fire the alarm, never a clear to 00:00.
  always_comb begin
    alarma_d = cnt_en && ({min_d_d, min_u_d, seg_d_d, seg_u_d} == ALARM_BCD);
  end
  assign alarma = alarma_q;
`endif

  assign inicio  = inicio_q;
  assign running = inicio_q;
  assign wrap    = wrap_q;
  assign seg_u   = seg_u_q;
  assign seg_d   = seg_d_q;
  assign min_u   = min_u_q;
  assign min_d   = min_d_q;

endmodule

// File: tb/tb_cronometro_bcd.sv
module tb_cronometro_bcd;
  localparam int unsigned AL_MIN = 1;
  localparam int unsigned AL_SEG = 0;
  localparam int ALARM_T = AL_MIN * 60 + AL_SEG;
`ifdef CRONO_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, tick, btn_start, btn_stop, btn_clear;
  logic inicio, running, wrap, alarma_obs;
  logic [3:0] seg_u, seg_d, min_u, min_d;

  always #5 clk = ~clk;

  cronometro_bcd #(.ALARM_MIN(AL_MIN), .ALARM_SEG(AL_SEG)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear),
    .inicio(inicio), .seg_u(seg_u), .seg_d(seg_d), .min_u(min_u), .min_d(min_d),
    .running(running),
`ifdef CRONO_ALARM_EN
    .alarma(alarma_obs),
`endif
    .wrap(wrap)
  );
`ifndef CRONO_ALARM_EN
  assign alarma_obs = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   secs = 0;
  logic exp_run = 1'b0;

  // {alarma, running, wrap, inicio, MM:SS digits}
  function automatic logic [19:0] expv(input int s, input logic run,
                                       input logic w, input logic a);
    int m, sc;
    m  = s / 60;
    sc = s % 60;
    return {a, run, w, run, 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic check_out();
    exp_t e;
    logic [19:0] obs;
    obs = {alarma_obs, running, wrap, inicio, min_d, min_u, seg_d, seg_u};
    e = sb.pop_front();
    n_vec++;
    assert (obs === e.exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  // One clock with tick=t; 'counted' says whether the model expects it to count.
  task automatic step(input string tag, input logic t, input logic counted);
    exp_t e;
    int   old_s;
    logic w, a;
    old_s = secs;
    w = 1'b0;
    a = 1'b0;
    if (counted) begin
      secs = (secs + 1) % 3600;
      w = (old_s == 3599);
      a = ALARM_ON && (secs == ALARM_T);
    end
    tick = t;
    e.tag = tag;
    e.exp = expv(secs, exp_run, w, a);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    check_out();
  endtask

  initial begin
    exp_t e0;
    rst_n = 1'b0; tick = 1'b0;
    btn_start = 1'b1; btn_stop = 1'b0; btn_clear = 1'b0;
    @(negedge clk);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b1;
    e0.tag = "reset"; e0.exp = expv(0, 1'b0, 1'b0, 1'b0);
    sb.push_back(e0);
    check_out();
    step("held_start", 1'b0, 1'b0);
    step("held_start", 1'b0, 1'b0);
    btn_start = 1'b0;
    step("rel_start", 1'b0, 1'b0);
    step("rel_start", 1'b0, 1'b0);

    // start latency: inicio high after the second edge
    btn_start = 1'b1;
    step("start_lat1", 1'b0, 1'b0);
    exp_run = 1'b1;
    step("start_lat2", 1'b0, 1'b0);
    btn_start = 1'b0;
    step("tick_in_run", 1'b0, 1'b0);
    for (int i = 0; i < 75; i++) step("count75", 1'b1, 1'b1);
    step("at_0115", 1'b0, 1'b0);

    while (secs != 3598) step("load", 1'b1, 1'b1);
    btn_stop = 1'b1;
    step("stop_smp", 1'b0, 1'b0);
    exp_run = 1'b0;
    step("stop_tick", 1'b1, 1'b1);
    btn_stop = 1'b0;
    for (int i = 0; i < 5; i++) step("pause_frozen", 1'b1, 1'b0);
    btn_start = 1'b1;
    step("resume_smp", 1'b0, 1'b0);
    exp_run = 1'b1;
    step("resume", 1'b0, 1'b0);
    btn_start = 1'b0;
    step("wrap_tick", 1'b1, 1'b1);
    step("wrap_drop", 1'b0, 1'b0);

    for (int i = 0; i < 42; i++) step("to_0042", 1'b1, 1'b1);
    btn_clear = 1'b1;
    step("clr_smp", 1'b0, 1'b0);
    secs = 0;
    exp_run = 1'b0;
    step("clr_tick", 1'b1, 1'b0);
    btn_clear = 1'b0;
    step("idle_tick", 1'b1, 1'b0);
    step("idle_tick", 1'b1, 1'b0);
    btn_stop = 1'b1;
    step("stop_idle", 1'b0, 1'b0);
    step("stop_idle", 1'b0, 1'b0);
    btn_stop = 1'b0;

    btn_start = 1'b1;
    step("run2_smp", 1'b0, 1'b0);
    exp_run = 1'b1;
    step("run2", 1'b0, 1'b0);
    btn_start = 1'b0;
    for (int i = 0; i < 3; i++) step("to_0003", 1'b1, 1'b1);
    btn_stop = 1'b1;
    step("stop2_smp", 1'b0, 1'b0);
    exp_run = 1'b0;
    step("stop2", 1'b0, 1'b0);
    btn_stop = 1'b0;
    step("pause2", 1'b1, 1'b0);
    step("pause2", 1'b0, 1'b0);
    btn_clear = 1'b1;
    btn_start = 1'b1;
    step("clr_start_smp", 1'b0, 1'b0);
    secs = 0;
    step("clr_start", 1'b0, 1'b0);
    step("clr_start_hold", 1'b1, 1'b0);
    btn_clear = 1'b0;
    btn_start = 1'b0;
    step("rel_both", 1'b0, 1'b0);
    step("rel_both", 1'b0, 1'b0);

    btn_start = 1'b1;
    step("run3_smp", 1'b0, 1'b0);
    exp_run = 1'b1;
    step("run3", 1'b0, 1'b0);
    btn_start = 1'b0;
    for (int i = 0; i < 187; i++) step("to_0307", 1'b1, 1'b1);
    rst_n = 1'b0;
    secs = 0;
    exp_run = 1'b0;
    step("rst_mid", 1'b1, 1'b0);
    rst_n = 1'b1;
    step("after_rst", 1'b0, 1'b0);
    step("after_rst_tick", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
